// File: rtl/pq_ctrl_pkg.sv
// Shared types for the priority-queue access arbiter: op codes, FSM states and
// the per-grant strobe/response control word.
package pq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_PUSH    = 2'b00,
    OP_POP     = 2'b01,
    OP_REPLACE = 2'b10
  } op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STROBE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic wrt;
    logic read;
    logic rsp;
    logic empty;
  } rsp_ctl_t;

  // An op that finds the queue empty never reads it; REPLACE degrades to a PUSH.
  function automatic rsp_ctl_t decode_op(op_t op, logic q_empty);
    rsp_ctl_t c;
    c = '0;
    case (op)
      OP_PUSH: c.wrt = 1'b1;
      OP_POP: begin
        c.rsp   = 1'b1;
        c.empty = q_empty;
        c.read  = !q_empty;
      end
      OP_REPLACE: begin
        c.wrt   = 1'b1;
        c.rsp   = 1'b1;
        c.empty = q_empty;
        c.read  = !q_empty;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping at N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   s;
  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      j = s[IW-1:0];
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/pq_access_arbiter.sv
// Round-robin access arbiter in front of a register-tree priority queue.
// Optional statistics counters (o_stat_* ports) under `define PQ_ARB_STATS_EN.
module pq_access_arbiter
  import pq_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int QUEUE_SIZE    = 2048,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 2*$clog2(QUEUE_SIZE)+2
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [2*NUM_REQ-1:0]          i_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_empty,
  output logic                          o_pq_wrt,
  output logic                          o_pq_read,
  output logic [DATA_WIDTH-1:0]         o_pq_data,
  input  logic [DATA_WIDTH-1:0]         i_pq_data,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count
`ifdef PQ_ARB_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]         o_stat_gnt,
  output logic [31:0]                   o_stat_settle_stall,
  output logic [31:0]                   o_stat_full_stall
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(QUEUE_SIZE+1);
  localparam int SW = $clog2(SETTLE_CYCLES+1);
  localparam logic [CW-1:0] FULL      = CW'(QUEUE_SIZE);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);

  arb_state_t              state, state_nxt;
  logic [CW-1:0]           count;
  logic [SW-1:0]           settle_cnt;
  logic [IW-1:0]           rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0]      elig, gnt_vec;
  logic                    gnt_any, take;
  op_t                     op_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   key_arr [NUM_REQ];
  op_t                     op_sel;
  logic [DATA_WIDTH-1:0]   key_sel;
  rsp_ctl_t                ctl_p1;
  logic [DATA_WIDTH-1:0]   key_p1;

  // Shadow count gates PUSH; settle timer gates anything that reads the root.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i]  = op_t'(i_op[2*i +: 2]);
      key_arr[i] = i_data[DATA_WIDTH*i +: DATA_WIDTH];
      case (op_arr[i])
        OP_PUSH:            elig[i] = i_req[i] && (count < FULL);
        OP_POP, OP_REPLACE: elig[i] = i_req[i] && (settle_cnt == '0 || count == '0);
        default:            elig[i] = 1'b0;
      endcase
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt_vec),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign take    = RSTn && (state == IDLE) && gnt_any;
  assign op_sel  = op_arr[gnt_idx];
  assign key_sel = key_arr[gnt_idx];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = STROBE;
      STROBE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- p0: grant cycle (IDLE) -> p1: strobe cycle (STROBE) ----
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      count      <= '0;
      settle_cnt <= '0;
      rr_ptr     <= '0;
      ctl_p1     <= '0;
      o_rsp_id   <= '0;
      o_rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == STROBE)         settle_cnt <= SETTLE_LD;
      else if (settle_cnt != '0)   settle_cnt <= settle_cnt - 1'b1;
      if (take) begin
        ctl_p1   <= decode_op(op_sel, count == '0);
        o_rsp_id <= gnt_idx;
        rr_ptr   <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        case (op_sel)
          OP_PUSH:    count <= count + 1'b1;
          OP_POP:     if (count != '0) count <= count - 1'b1;
          OP_REPLACE: if (count == '0) count <= count + 1'b1;
          default:    count <= count;
        endcase
        if (op_sel != OP_PUSH) o_rsp_data <= (count == '0) ? '0 : i_pq_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (take) key_p1 <= key_sel;
  end

  assign o_gnt       = take ? gnt_vec : '0;
  assign o_pq_wrt    = (state == STROBE) && ctl_p1.wrt;
  assign o_pq_read   = (state == STROBE) && ctl_p1.read;
  assign o_rsp_valid = (state == STROBE) && ctl_p1.rsp;
  assign o_rsp_empty = (state == STROBE) && ctl_p1.empty;
  assign o_pq_data   = o_pq_wrt ? key_p1 : '0;
  assign o_count     = count;

`ifdef PQ_ARB_STATS_EN
  logic settle_wait, full_wait;

  always_comb begin
    settle_wait = 1'b0;
    full_wait   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req[i]) begin
        case (op_arr[i])
          OP_PUSH:            if (count == FULL) full_wait = 1'b1;
          OP_POP, OP_REPLACE: if (count != '0 && settle_cnt != '0) settle_wait = 1'b1;
          default:            ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      o_stat_gnt          <= '0;
      o_stat_settle_stall <= '0;
      o_stat_full_stall   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (o_gnt[i]) o_stat_gnt[32*i +: 32] <= o_stat_gnt[32*i +: 32] + 32'd1;
      if (settle_wait) o_stat_settle_stall <= o_stat_settle_stall + 32'd1;
      if (full_wait)   o_stat_full_stall   <= o_stat_full_stall + 32'd1;
    end
  end
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
    a_key_nonzero: assert property (@(posedge CLK) disable iff (!RSTn)
      (i_req[g] && op_arr[g] != OP_POP) |-> (key_arr[g] != '0));
    a_req_held: assert property (@(posedge CLK) disable iff (!RSTn)
      (i_req[g] && !o_gnt[g]) |=> i_req[g]);
  end

endmodule

// File: tb/tb_pq_access_arbiter.sv
// Scoreboard bench for pq_access_arbiter with a small behavioural min-queue.
module tb_pq_access_arbiter;
  import pq_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int QS = 4;
  localparam int DW = 16;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic [N-1:0]      req;
  logic [2*N-1:0]    op;
  logic [N*DW-1:0]   data;
  logic [N-1:0]      o_gnt;
  logic              o_rsp_valid, o_rsp_empty, o_pq_wrt, o_pq_read;
  logic [1:0]        o_rsp_id;
  logic [DW-1:0]     o_rsp_data, o_pq_data, pq_root;
  logic [2:0]        o_count;

  int checks = 0;
  int errors = 0;

  logic [3:0]  exp_gnt_q[$];
  logic [17:0] exp_stb_q[$];
  logic [18:0] exp_rsp_q[$];

  pq_access_arbiter #(.NUM_REQ(N), .QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RSTn(RSTn), .i_req(req), .i_op(op), .i_data(data),
    .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
    .o_rsp_data(o_rsp_data), .o_rsp_empty(o_rsp_empty), .o_pq_wrt(o_pq_wrt),
    .o_pq_read(o_pq_read), .o_pq_data(o_pq_data), .i_pq_data(pq_root),
    .o_count(o_count)
  );

  // Behavioural min-queue standing in for the real queue instance.
  int model[$];
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      model.delete();
      pq_root <= '0;
    end else begin
      int mi;
      if (o_pq_read && model.size() > 0) begin
        mi = 0;
        foreach (model[k]) if (model[k] < model[mi]) mi = k;
        model.delete(mi);
      end
      if (o_pq_wrt) model.push_back(int'(o_pq_data));
      if (model.size() == 0) pq_root <= '0;
      else begin
        mi = 0;
        foreach (model[k]) if (model[k] < model[mi]) mi = k;
        pq_root <= DW'(model[mi]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard.
  logic [N-1:0] prev_gnt;
  logic         prev_wrt;
  always @(negedge CLK) begin
    if (!RSTn) begin
      prev_gnt = '0;
      prev_wrt = 1'b0;
    end else begin
      if (o_gnt != '0) begin
        chk("gnt_gap", 32'(prev_gnt), 32'd0);
        if (exp_gnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected: got 0x%0h, expected none", o_gnt);
        end else chk("gnt", 32'(o_gnt), 32'(exp_gnt_q.pop_front()));
      end
      if (o_pq_wrt || o_pq_read) begin
        chk("stb_latency", 32'(prev_gnt != '0), 32'd1);
        if (o_pq_wrt) chk("wrt_adjacent", 32'(prev_wrt), 32'd0);
        if (exp_stb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stb_unexpected: got wrt=%0b rd=%0b data=0x%0h, expected none",
                   o_pq_wrt, o_pq_read, o_pq_data);
        end else chk("stb", 32'({o_pq_wrt, o_pq_read, o_pq_data}), 32'(exp_stb_q.pop_front()));
      end
      if (o_rsp_valid) begin
        chk("rsp_latency", 32'(prev_gnt != '0), 32'd1);
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got id=%0d data=0x%0h empty=%0b, expected none",
                   o_rsp_id, o_rsp_data, o_rsp_empty);
        end else chk("rsp", 32'({o_rsp_id, o_rsp_data, o_rsp_empty}), 32'(exp_rsp_q.pop_front()));
      end
      prev_gnt = o_gnt;
      prev_wrt = o_pq_wrt;
    end
  end

  task automatic exp_g(input int c);
    logic [3:0] v;
    v = '0; v[c] = 1'b1;
    exp_gnt_q.push_back(v);
  endtask
  task automatic exp_s(input logic w, input logic r, input logic [DW-1:0] d);
    exp_stb_q.push_back({w, r, d});
  endtask
  task automatic exp_r(input logic [1:0] id, input logic [DW-1:0] d, input logic e);
    exp_rsp_q.push_back({id, d, e});
  endtask

  task automatic set_req(input int c, input op_t o, input logic [DW-1:0] d);
    op[2*c +: 2]   = o;
    data[DW*c +: DW] = d;
    req[c]         = 1'b1;
  endtask

  // Holds requests until granted; returns the cycle index of the last grant.
  task automatic run(output int last);
    int n;
    logic [N-1:0] g;
    n = 0; last = 0;
    while (req != '0 && n < 100) begin
      @(negedge CLK);
      n++;
      g = o_gnt;
      if (g != '0) last = n;
      @(posedge CLK); #1;
      req = req & ~g;
    end
    if (req != '0) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got req=0x%0h pending, expected 0x0", req);
      req = '0;
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    req  = '0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req = '0; op = '0; data = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt",   32'(o_gnt), 32'd0);
    chk("rst_wrt",   32'(o_pq_wrt), 32'd0);
    chk("rst_read",  32'(o_pq_read), 32'd0);
    chk("rst_rsp",   32'(o_rsp_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_rdata", 32'(o_rsp_data), 32'd0);
    RSTn = 1'b1;

    // Single PUSH
    exp_g(0); exp_s(1'b1, 1'b0, 16'd5);
    set_req(0, OP_PUSH, 16'd5);
    run(n);
    chk("push_gnt_cycle", 32'(n), 32'd1);
    chk("push_count", 32'(o_count), 32'd1);
    idle(3); do_reset();

    // Four concurrent PUSHes, round-robin two cycles apart
    exp_g(0); exp_g(1); exp_g(2); exp_g(3);
    exp_s(1'b1, 1'b0, 16'd9); exp_s(1'b1, 1'b0, 16'd7);
    exp_s(1'b1, 1'b0, 16'd3); exp_s(1'b1, 1'b0, 16'd8);
    set_req(0, OP_PUSH, 16'd9); set_req(1, OP_PUSH, 16'd7);
    set_req(2, OP_PUSH, 16'd3); set_req(3, OP_PUSH, 16'd8);
    run(n);
    chk("rr_last_gnt", 32'(n), 32'd7);
    chk("rr_count", 32'(o_count), 32'd4);

    // POP waits out the settle window
    exp_g(2); exp_s(1'b0, 1'b1, 16'd0); exp_r(2'd2, 16'd3, 1'b0);
    set_req(2, OP_POP, 16'd0);
    run(n);
    chk("pop_settle_wait", 32'(n), 32'd8);
    chk("pop_count", 32'(o_count), 32'd3);
    idle(3); do_reset();

    // Empty POP, empty REPLACE (acts as PUSH), then a real REPLACE
    exp_g(1); exp_r(2'd1, 16'd0, 1'b1);
    set_req(1, OP_POP, 16'd0);
    run(n);
    chk("epop_count", 32'(o_count), 32'd0);
    exp_g(3); exp_s(1'b1, 1'b0, 16'd4); exp_r(2'd3, 16'd0, 1'b1);
    set_req(3, OP_REPLACE, 16'd4);
    run(n);
    chk("erepl_wait", 32'(n), 32'd2);
    chk("erepl_count", 32'(o_count), 32'd1);
    exp_g(0); exp_s(1'b1, 1'b1, 16'd2); exp_r(2'd0, 16'd4, 1'b0);
    set_req(0, OP_REPLACE, 16'd2);
    run(n);
    chk("repl_wait", 32'(n), 32'd8);
    chk("repl_count", 32'(o_count), 32'd1);
    idle(3); do_reset();

    // Fill, stalled PUSH, POP served first, then the PUSH
    exp_g(0); exp_g(1); exp_g(2); exp_g(3);
    exp_s(1'b1, 1'b0, 16'd6); exp_s(1'b1, 1'b0, 16'd4);
    exp_s(1'b1, 1'b0, 16'd9); exp_s(1'b1, 1'b0, 16'd5);
    set_req(0, OP_PUSH, 16'd6); set_req(1, OP_PUSH, 16'd4);
    set_req(2, OP_PUSH, 16'd9); set_req(3, OP_PUSH, 16'd5);
    run(n);
    chk("fill_count", 32'(o_count), 32'd4);
    exp_g(2); exp_s(1'b0, 1'b1, 16'd0); exp_r(2'd2, 16'd4, 1'b0);
    exp_g(1); exp_s(1'b1, 1'b0, 16'd7);
    set_req(1, OP_PUSH, 16'd7); set_req(2, OP_POP, 16'd0);
    run(n);
    chk("full_last_gnt", 32'(n), 32'd10);
    chk("full_count", 32'(o_count), 32'd4);
    idle(3); do_reset();

    // Reset asserted during STROBE
    exp_g(0);
    set_req(0, OP_PUSH, 16'd5);
    @(negedge CLK);
    @(posedge CLK); #1;
    chk("mid_in_strobe", 32'(o_pq_wrt), 32'd1);
    chk("mid_count_pre", 32'(o_count), 32'd1);
    RSTn = 1'b0;
    #1;
    chk("mid_gnt",   32'(o_gnt), 32'd0);
    chk("mid_wrt",   32'(o_pq_wrt), 32'd0);
    chk("mid_rsp",   32'(o_rsp_valid), 32'd0);
    chk("mid_pdata", 32'(o_pq_data), 32'd0);
    chk("mid_count", 32'(o_count), 32'd0);
    req = '0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    idle(2);
    chk("mid_count_post", 32'(o_count), 32'd0);

    chk("sb_gnt_drain", 32'(exp_gnt_q.size()), 32'd0);
    chk("sb_stb_drain", 32'(exp_stb_q.size()), 32'd0);
    chk("sb_rsp_drain", 32'(exp_rsp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
